inst_buffer: RTL and testbench
==============================

Name: inst_buffer

Overview:
- Instruction buffer at the receive end of the predecode-to-ibuffer interface.
- Accepts compacted blocks of up to BLOCK_INST_SIZE pre-decoded instructions per cycle, together with their FSQ index, block offsets and fetch-exception flags.
- Stores them in a circular FIFO and presents up to DECODE_WIDTH in-order instructions per cycle to the decode stage.
- Raises ibuf_full back-pressure to predecode and is flushed on a frontend redirect.

Parameters:
- BLOCK_INST_SIZE, 8, maximum instructions written per cycle.
- DEPTH, 32, buffer entries; power of two, at least 2*BLOCK_INST_SIZE.
- DECODE_WIDTH, 4, maximum instructions read per cycle.
- FSQ_WIDTH, 5, width of the FSQ index.
- OFFSET_WIDTH, 4, width of the per-instruction offset within its fetch block.

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous reset, active-high.
- flush  input  1  frontend redirect; empties the buffer.
- pd_en  input  BLOCK_INST_SIZE  lane-valid mask; contiguous from lane 0.
- pd_num  input  $clog2(BLOCK_INST_SIZE)+1  count of valid lanes; equals popcount(pd_en).
- pd_inst  input  BLOCK_INST_SIZE*32  instruction per lane.
- pd_offset  input  BLOCK_INST_SIZE*OFFSET_WIDTH  offset of each lane within its fetch block.
- pd_fsq_idx  input  FSQ_WIDTH  FSQ index shared by all lanes.
- pd_ipf  input  1  instruction page fault for the block.
- pd_iam  input  1  instruction address misaligned for the block.
- ibuf_full  output  1  buffer cannot accept a full block.
- dec_ready  input  1  decode accepts the presented group this cycle.
- dec_valid  output  DECODE_WIDTH  per-slot valid; contiguous from slot 0.
- dec_inst  output  DECODE_WIDTH*32  instruction per slot.
- dec_offset  output  DECODE_WIDTH*OFFSET_WIDTH  offset per slot.
- dec_fsq_idx  output  DECODE_WIDTH*FSQ_WIDTH  FSQ index per slot.
- dec_exc  output  DECODE_WIDTH*2  {ipf, iam} per slot.

Behaviour:
- Reset: while rst=1 at a rising edge, head=0, tail=0 and count=0. Outputs after reset: ibuf_full=0, dec_valid=0.
- Storage: DEPTH entries, each holding {inst, offset, fsq_idx, ipf, iam}. Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. count is $clog2(DEPTH)+1 bits.
- Write condition: wr = pd_en[0] & ~ibuf_full & ~flush.
  - On wr, lane i (i < pd_num) is stored at entry (tail+i) mod DEPTH.
  - tail advances by pd_num, wrapping past DEPTH-1.
  - When ibuf_full=1, lanes are dropped; predecode holds its data because it samples the same ibuf_full.
- ibuf_full = (count > DEPTH - BLOCK_INST_SIZE). Combinational from registered count; no input feeds it.
- Read presentation:
  - Combinational from registered state: dec_valid[j] = (j < min(count, DECODE_WIDTH)) & ~flush.
  - Slot j shows entry (head+j) mod DEPTH.
- Read condition: rd_num = dec_ready ? popcount(dec_valid) : 0. head advances by rd_num.
- Update rule: count_next = count + (wr ? pd_num : 0) - rd_num. Simultaneous read and write are allowed in the same cycle.
- Latency: an instruction written at edge T first appears on dec_* in the cycle after T (one-cycle latency).
- Flush:
  - At the next edge head=tail=count=0.
  - Any same-cycle write is discarded and no read is counted.
  - flush has priority over wr and rd; rst has priority over flush.
- Empty: dec_valid=0 and dec_ready is ignored.
- Full: a count of exactly DEPTH-BLOCK_INST_SIZE still accepts one full block; count never exceeds DEPTH.
- Wrap-around: a block straddling entry DEPTH-1 is split across the end and the start of storage; order is preserved.
- pd_num=0 with pd_en[0]=1 is illegal. Under simulation an assertion fires; no state change occurs.

Optional Feature:
- Macro: IBUF_BYPASS_EN.
- Defined: when count==0 and wr=1, lanes 0..min(pd_num, DECODE_WIDTH)-1 drive dec_* combinationally in the same cycle.
  - If dec_ready=1, those lanes are not stored: tail advances by pd_num and count_next = pd_num - forwarded.
  - If dec_ready=0, all lanes are stored normally.
- Undefined: no bypass; the one-cycle minimum latency holds.

Test Plan:
- Reset then write 8 lanes with fsq_idx=3, offsets 0..7, dec_ready=1 -> next cycle dec_valid=4'b1111 showing offsets 0..3; following cycle offsets 4..7; then dec_valid=0 and count=0.
- Hold dec_ready=0 and write 8-lane blocks each cycle -> count goes 8,16,24 and ibuf_full=1 at count=32 (>24); the fifth block, presented while ibuf_full=1, is dropped and count stays 32.
- Write blocks of pd_num=5 with a 4/cycle drain until tail wraps (tail 30 -> 3) -> instructions emerge in exact write order across the wrap.
- Same-cycle write of 3 and read of 4 with count=6 -> count_next=5; head+4, tail+3.
- Assert flush while count=12 and a write is presented -> dec_valid=0 that cycle; the next cycle has count=0, head=tail=0 and no entry from the discarded block.
- With IBUF_BYPASS_EN, write pd_num=2 into an empty buffer with dec_ready=1 -> dec_valid=4'b0011 in the same cycle and count stays 0; without the macro, dec_valid=0 that cycle and 4'b0011 the next.

Source files
------------

// File: rtl/inst_buffer.sv
// inst_buffer: circular instruction FIFO between predecode and decode.
// Latency: one cycle from write to first visibility on dec_* (zero-cycle bypass
//   into an empty buffer when IBUF_BYPASS_EN is defined).
// Backpressure: ibuf_full when a full block might not fit; decode pulls with dec_ready.
//
// Ports:
//   clk, rst (sync, active-high), flush (frontend redirect, empties buffer)
//   pd_*      : write side, up to BLOCK_INST_SIZE lanes per cycle, contiguous from lane 0
//   ibuf_full : predecode must hold its block while high
//   dec_*     : up to DECODE_WIDTH in-order slots, dec_ready consumes all valid slots
// Optional macro: IBUF_BYPASS_EN (forward writes into an empty buffer same-cycle).
module inst_buffer #(
  parameter int BLOCK_INST_SIZE = 8,
  parameter int DEPTH           = 32,
  parameter int DECODE_WIDTH    = 4,
  parameter int FSQ_WIDTH       = 5,
  parameter int OFFSET_WIDTH    = 4
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 flush,
  input  logic [BLOCK_INST_SIZE-1:0]           pd_en,
  input  logic [$clog2(BLOCK_INST_SIZE):0]     pd_num,
  input  logic [BLOCK_INST_SIZE*32-1:0]        pd_inst,
  input  logic [BLOCK_INST_SIZE*OFFSET_WIDTH-1:0] pd_offset,
  input  logic [FSQ_WIDTH-1:0]                 pd_fsq_idx,
  input  logic                                 pd_ipf,
  input  logic                                 pd_iam,
  output logic                                 ibuf_full,
  input  logic                                 dec_ready,
  output logic [DECODE_WIDTH-1:0]              dec_valid,
  output logic [DECODE_WIDTH*32-1:0]           dec_inst,
  output logic [DECODE_WIDTH*OFFSET_WIDTH-1:0] dec_offset,
  output logic [DECODE_WIDTH*FSQ_WIDTH-1:0]    dec_fsq_idx,
  output logic [DECODE_WIDTH*2-1:0]            dec_exc
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int NUM_W = $clog2(BLOCK_INST_SIZE) + 1;
  localparam logic [CNT_W-1:0] FULL_THR = CNT_W'(DEPTH - BLOCK_INST_SIZE);
  localparam logic [CNT_W-1:0] DW_CNT   = CNT_W'(DECODE_WIDTH);

  typedef struct packed {
    logic [31:0]             inst;
    logic [OFFSET_WIDTH-1:0] offset;
    logic [FSQ_WIDTH-1:0]    fsq_idx;
    logic                    ipf;
    logic                    iam;
  } entry_t;

  entry_t           mem [DEPTH];
  entry_t           lane [BLOCK_INST_SIZE];
  entry_t           slot [DECODE_WIDTH];
  logic [PTR_W-1:0] head, tail;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] avail;    // slots presented to decode this cycle
  logic [CNT_W-1:0] rd_num;
  logic             wr;
  logic             bypass;

  assign ibuf_full = (count > FULL_THR);
  assign wr        = pd_en[0] & ~ibuf_full & ~flush;

  always_comb begin
    for (int i = 0; i < BLOCK_INST_SIZE; i++) begin
      lane[i].inst    = pd_inst[i*32 +: 32];
      lane[i].offset  = pd_offset[i*OFFSET_WIDTH +: OFFSET_WIDTH];
      lane[i].fsq_idx = pd_fsq_idx;
      lane[i].ipf     = pd_ipf;
      lane[i].iam     = pd_iam;
    end
  end

  // Bypassed lanes are still written to storage; head advancing past them
  // on the same edge is what keeps them from being presented twice.
  always_comb begin
    bypass = 1'b0;
`ifdef IBUF_BYPASS_EN
    bypass = wr & (count == '0);
`endif
    if (bypass)
      avail = (CNT_W'(pd_num) > DW_CNT) ? DW_CNT : CNT_W'(pd_num);
    else
      avail = (count > DW_CNT) ? DW_CNT : count;
    if (flush)
      avail = '0;
    rd_num = dec_ready ? avail : '0;
  end

  always_comb begin
    for (int j = 0; j < DECODE_WIDTH; j++) begin
      slot[j] = mem[head + PTR_W'(j)];
      if (bypass)
        slot[j] = lane[j];
      dec_valid[j]                                 = (CNT_W'(j) < avail);
      dec_inst[j*32 +: 32]                         = slot[j].inst;
      dec_offset[j*OFFSET_WIDTH +: OFFSET_WIDTH]   = slot[j].offset;
      dec_fsq_idx[j*FSQ_WIDTH +: FSQ_WIDTH]        = slot[j].fsq_idx;
      dec_exc[j*2 +: 2]                            = {slot[j].ipf, slot[j].iam};
    end
  end

  // Storage needs no reset; validity is tracked by head/count.
  always_ff @(posedge clk) begin
    if (wr) begin
      for (int i = 0; i < BLOCK_INST_SIZE; i++) begin
        if (NUM_W'(i) < pd_num)
          mem[tail + PTR_W'(i)] <= lane[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (wr)
        tail <= tail + PTR_W'(pd_num);
      head  <= head + PTR_W'(rd_num);
      count <= count + (wr ? CNT_W'(pd_num) : '0) - rd_num;
    end
  end

  // A valid block must carry a lane count matching its contiguous mask.
  always_ff @(posedge clk) begin
    if (!rst && pd_en[0]) begin
      assert (pd_num != '0);
      assert ($countones(pd_en) == int'(pd_num));
    end
  end

endmodule

// File: tb/tb_inst_buffer.sv
// tb_inst_buffer: scoreboard bench for inst_buffer.
// Drives inputs just after the rising edge, checks outputs on the falling edge.
// Also builds with IBUF_BYPASS_EN defined; the model follows the macro.
module tb_inst_buffer;
  localparam int B  = 8;
  localparam int D  = 32;
  localparam int DW = 4;
  localparam int FW = 5;
  localparam int OW = 4;

  logic              clk = 1'b0;
  logic              rst, flush, dec_ready;
  logic [B-1:0]      pd_en;
  logic [3:0]        pd_num;
  logic [B*32-1:0]   pd_inst;
  logic [B*OW-1:0]   pd_offset;
  logic [FW-1:0]     pd_fsq_idx;
  logic              pd_ipf, pd_iam;
  logic              ibuf_full;
  logic [DW-1:0]     dec_valid;
  logic [DW*32-1:0]  dec_inst;
  logic [DW*OW-1:0]  dec_offset;
  logic [DW*FW-1:0]  dec_fsq_idx;
  logic [DW*2-1:0]   dec_exc;

  always #5 clk = ~clk;

  inst_buffer dut (
    .clk(clk), .rst(rst), .flush(flush),
    .pd_en(pd_en), .pd_num(pd_num), .pd_inst(pd_inst), .pd_offset(pd_offset),
    .pd_fsq_idx(pd_fsq_idx), .pd_ipf(pd_ipf), .pd_iam(pd_iam),
    .ibuf_full(ibuf_full), .dec_ready(dec_ready), .dec_valid(dec_valid),
    .dec_inst(dec_inst), .dec_offset(dec_offset), .dec_fsq_idx(dec_fsq_idx),
    .dec_exc(dec_exc)
  );

  typedef struct packed {
    logic [31:0]   inst;
    logic [OW-1:0] off;
    logic [FW-1:0] fsq;
    logic [1:0]    exc;
  } ent_t;

  ent_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   seq    = 0;
  int   mhead  = 0;
  int   mtail  = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int n, input int fsq, input bit rdy, input bit fl,
                       input bit ipf, input bit iam);
    pd_en     = '0;
    pd_inst   = '0;
    pd_offset = '0;
    for (int i = 0; i < n; i++) begin
      pd_en[i]              = 1'b1;
      pd_inst[i*32 +: 32]   = 32'hC0DE_0000 + 32'(seq);
      pd_offset[i*OW +: OW] = OW'(i);
      seq++;
    end
    pd_num     = 4'(n);
    pd_fsq_idx = FW'(fsq);
    pd_ipf     = ipf;
    pd_iam     = iam;
    dec_ready  = rdy;
    flush      = fl;
  endtask

  task automatic push_lanes();
    ent_t e;
    for (int i = 0; i < int'(pd_num); i++) begin
      e.inst = pd_inst[i*32 +: 32];
      e.off  = pd_offset[i*OW +: OW];
      e.fsq  = pd_fsq_idx;
      e.exc  = {pd_ipf, pd_iam};
      q.push_back(e);
    end
    mtail = (mtail + int'(pd_num)) % D;
  endtask

  // One cycle: check presented outputs against the scoreboard, then update it.
  task automatic tick();
    int          exp_n;
    bit          full_m, wr_m, pushed;
    logic [DW-1:0] exp_v;
    ent_t        e;
    @(negedge clk);
    full_m = (q.size() > D - B);
    chk("ibuf_full", 64'(ibuf_full), 64'(full_m));
    chk("count", 64'(dut.count), 64'(q.size()));
    chk("head", 64'(dut.head), 64'(mhead));
    chk("tail", 64'(dut.tail), 64'(mtail));
    wr_m   = pd_en[0] && !full_m && !flush;
    pushed = 1'b0;
`ifdef IBUF_BYPASS_EN
    if (wr_m && q.size() == 0) begin
      push_lanes();
      pushed = 1'b1;
    end
`endif
    exp_n = flush ? 0 : ((q.size() < DW) ? q.size() : DW);
    exp_v = '0;
    for (int j = 0; j < exp_n; j++) exp_v[j] = 1'b1;
    chk("dec_valid", 64'(dec_valid), 64'(exp_v));
    for (int j = 0; j < exp_n; j++) begin
      e.inst = dec_inst[j*32 +: 32];
      e.off  = dec_offset[j*OW +: OW];
      e.fsq  = dec_fsq_idx[j*FW +: FW];
      e.exc  = dec_exc[j*2 +: 2];
      chk("dec_slot", 64'(e), 64'(q[j]));
    end
    if (flush) begin
      q.delete();
      mhead = 0;
      mtail = 0;
    end else begin
      if (dec_ready) begin
        for (int j = 0; j < exp_n; j++) void'(q.pop_front());
        mhead = (mhead + exp_n) % D;
      end
      if (wr_m && !pushed) push_lanes();
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    drive(0, 0, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 20 && q.size() != 0; k++) tick();
    if (q.size() != 0) chk("drain_timeout", 64'(q.size()), 64'd0);
    tick();
  endtask

  initial begin
    rst = 1'b1;
    drive(0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state
    tick();

    // One 8-lane block drained in two groups of four
    drive(8, 3, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    drive(0, 0, 1'b1, 1'b0, 1'b0, 1'b0);
    repeat (3) tick();

    // Fill to full with decode stalled; fifth block is dropped
    for (int k = 0; k < 5; k++) begin
      drive(8, 1, 1'b0, 1'b0, 1'b0, 1'b1);
      tick();
    end
    drain();

    // Blocks of five against a four-wide drain: tail wraps, order preserved
    for (int k = 0; k < 20; k++) begin
      drive(5, k, 1'b1, 1'b0, k[0], 1'b0);
      tick();
    end
    drain();

    // Simultaneous write of 3 and read of 4 from count 6
    drive(6, 2, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    drive(3, 2, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    drive(0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    drain();

    // Flush at count 12 with a write presented
    drive(8, 4, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    drive(4, 4, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    drive(8, 6, 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    drive(0, 0, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();

    // Two lanes into an empty buffer with decode ready
    drive(2, 5, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    drive(0, 0, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    tick();

    // Random traffic
    for (int k = 0; k < 300; k++) begin
      drive($urandom_range(0, 8), $urandom_range(0, 31), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 19) == 0), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      tick();
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
